rv_fetch_queue: RTL
===================

RV_FETCH_QUEUE -- requirements
Module: rv_fetch_queue

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, which sets the PC width in bits.
REQ-002 The block SHALL have parameter IMEM_DEPTH, default 32, giving the instruction memory size in 32-bit words (power of two).
REQ-003 The block SHALL have parameter QDEPTH, default 4, giving the queue entry count (power of two, ≥2).
REQ-004 The block SHALL have parameter RESET_PC, default 0, giving the first fetch address, word aligned.
REQ-005 The block SHALL have parameter STOP_ON_CTRL, default 1: when 1, fetch stops after a control-transfer instruction; when 0, fetch continues sequentially.
REQ-006 The block SHALL have port clk, input, width 1: clock, all state on its rising edge.
REQ-007 The block SHALL have port rst, input, width 1: reset, synchronous, active-high.
REQ-008 The block SHALL have port imem_req, output, width 1: read strobe to instruction memory.
REQ-009 The block SHALL have port imem_addr, output, width log2(IMEM_DEPTH): word address, equal to fetch_pc[2+:log2(IMEM_DEPTH)].
REQ-010 The block SHALL have port imem_rdata, input, width 32: read data, valid exactly 1 cycle after imem_req.
REQ-011 The block SHALL have port redirect_valid, input, width 1: one-cycle pulse for a taken branch/jump or other PC change.
REQ-012 The block SHALL have port redirect_pc, input, width XLEN: target PC, sampled when redirect_valid=1.
REQ-013 The block SHALL have port out_valid, output, width 1: head entry valid.
REQ-014 The block SHALL have port out_ready, input, width 1: decode accepts head.
REQ-015 The block SHALL have port out_instr, output, width 32: head instruction.
REQ-016 The block SHALL have port out_pc, output, width XLEN: PC of head instruction.
REQ-017 The block SHALL have port out_ctrl, output, width 1: head opcode[6:0] is 1100011 (branch), 1101111 (JAL) or 1100111 (JALR).
REQ-018 The block SHALL have port count, output, width log2(QDEPTH)+1: occupied entries.

Function
REQ-019 Pop SHALL occur on an edge with out_valid=1 and out_ready=1; out_* SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 imem_req SHALL be 1 only in RUN state, with no redirect this cycle, and when count + inflight + pop-free slot < QDEPTH+1 (i.e., a slot is guaranteed for the response); on each request, fetch_pc SHALL advance by 4.
REQ-021 The response SHALL be pushed with its request PC on the edge after the request; the queue SHALL never overflow and SHALL be FIFO ordered.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; push into an empty queue SHALL make out_valid=1 on the next cycle (no bypass).
REQ-023 Latency: request at cycle N, entry visible at out_* in cycle N+2.
REQ-024 The FSM SHALL have states RUN and HOLD; RUN→HOLD when STOP_ON_CTRL=1 and a pushed instruction is a control transfer; HOLD→RUN only on redirect_valid; with STOP_ON_CTRL=0, HOLD SHALL be unreachable.
REQ-025 Redirect SHALL have top priority: on that edge the queue is flushed (count=0), an in-flight response is discarded, any same-cycle pop/push is ignored, fetch_pc is set to {redirect_pc[XLEN-1:2],2'b00}, and state goes to RUN.
REQ-026 After redirect, the first request SHALL issue in the next cycle and the target instruction SHALL be at out_* 2 cycles later.
REQ-027 Word address SHALL wrap modulo IMEM_DEPTH; fetch_pc itself SHALL wrap modulo 2^XLEN.
REQ-028 When out_valid=0, out_instr SHALL read 32'h00000013 (NOP), out_ctrl SHALL be 0, and out_pc SHALL be 0.

Reset
REQ-029 On rst: fetch_pc=RESET_PC, state RUN, count=0, inflight=0, pointers 0, out_valid=0, imem_req=0; queue storage need not be cleared.
REQ-030 rst mid-operation SHALL override redirect, push and pop; the first request SHALL issue in the first cycle after rst deasserts.

Structure
REQ-031 Opcode constants (OP_BRANCH, OP_JAL, OP_JALR, NOP encoding) SHALL live in a shared package rv_pkg, reused by the core.
REQ-032 Queue storage/pointers SHALL be one sub-module, rv_sync_fifo (parameters WIDTH, DEPTH, with flush input); fetch control and FSM stay in rv_fetch_queue.

Verification
REQ-033 Reset, with straight-line ADDI words at 0..7 and out_ready=1: out_pc sequence 0,4,8,… with the first out_valid 2 cycles after rst falls; 1 instruction per cycle thereafter.
REQ-034 out_ready=0 for 10 cycles: count saturates at 4, imem_req=0, no instruction is lost or duplicated after release.
REQ-035 With STOP_ON_CTRL=1 and a BEQ at PC 8: entries 0,4,8 are delivered, then imem_req=0; redirect_pc=0x14 → next out_pc=0x14 2 cycles later.
REQ-036 With STOP_ON_CTRL=0, the same program: fetch continues at 0xC; redirect to 0x0 with full queue and a same-cycle pop → count=0, 0xC response dropped, next out_pc=0x0.
REQ-037 Wrap/misalign: redirect_pc=0x7E (IMEM_DEPTH=32) → out_pc=0x7C, then 0x80 reading word 0.
REQ-038 rst asserted with queue half full and a request in flight → out_valid=0 next cycle, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V encodings and the fetch queue FSM state type.
package rv_pkg;

    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic {
        FQ_RUN  = 1'b0,
        FQ_HOLD = 1'b1
    } fq_state_t;

    function automatic logic is_ctrl(input logic [6:0] opcode);
        return (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
    endfunction

endpackage

// File: rtl/rv_sync_fifo.sv
// Synchronous FIFO with flush; head entry is read combinationally (show-ahead).
module rv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rv_fetch_queue.sv
// Instruction fetch unit: issues word reads to a 1-cycle instruction memory and
// queues {pc, instr} pairs for decode, with redirect flush and stop-on-branch.
module rv_fetch_queue
    import rv_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              IMEM_DEPTH   = 32,
    parameter int              QDEPTH       = 4,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter bit              STOP_ON_CTRL = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          imem_req,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_rdata,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_instr,
    output logic [XLEN-1:0]               out_pc,
    output logic                          out_ctrl,
    output logic [$clog2(QDEPTH):0]       count
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int OW = $clog2(QDEPTH) + 2;

    fq_state_t        state;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  req_pc;
    logic             inflight;
    logic             pop;
    logic             push;
    logic             stop_now;
    logic [OW-1:0]    occupied;
    logic [OW-1:0]    limit;
    logic [XLEN+31:0] head;
    logic             empty;
    logic             unused_full;
    logic             unused_rpc_lsb;

    assign pop  = out_valid && out_ready;
    assign push = inflight;

    // A control transfer arriving this cycle also blocks the request that
    // would otherwise go out alongside it, so nothing past it gets fetched.
    assign stop_now = STOP_ON_CTRL && push && is_ctrl(imem_rdata[6:0]);

    // Request only if its response is guaranteed a slot on the following edge.
    assign occupied = OW'(count) + OW'(inflight);
    assign limit    = OW'(QDEPTH) + OW'(pop);

    assign imem_req  = !rst && (state == FQ_RUN) && !redirect_valid && !stop_now
                       && (occupied < limit);
    assign imem_addr = fetch_pc[2 +: AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            state    <= FQ_RUN;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
            state    <= FQ_RUN;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (stop_now) state <= FQ_HOLD;
        end
    end

    rv_sync_fifo #(
        .WIDTH(XLEN + 32),
        .DEPTH(QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .wdata ({req_pc, imem_rdata}),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (unused_full)
    );

    assign unused_rpc_lsb = ^redirect_pc[1:0];

    assign out_valid = !empty;
    assign out_instr = out_valid ? head[31:0] : NOP_INSTR;
    assign out_pc    = out_valid ? head[XLEN+31:32] : '0;
    assign out_ctrl  = out_valid && is_ctrl(head[6:0]);

endmodule
